// File: rtl/wb_scan_chain_ctrl.sv
// wb_scan_chain_ctrl: Wishbone slave that exchanges or reads back a shadow image through a scan chain
module wb_scan_chain_ctrl #(
    parameter int CHAIN_LEN = 64
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        scan_enable,
    output logic        scan_in,
    input  logic        scan_out,
    output logic        proc_en,
    input  logic        halt_in,
    output logic        irq_o
);
    localparam int SHADOW_W = (CHAIN_LEN + 31) / 32;
    localparam int SB = SHADOW_W * 32;
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam logic [SB-1:0] MASK = {SB{1'b1}} >> (SB - CHAIN_LEN);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t               r_state;
    logic [SB-1:0]        r_shadow;
    logic [CHAIN_LEN-1:0] r_sr;
    logic [CW-1:0]        r_cnt;
    logic [31:0]          r_dat;
    logic                 r_ack, r_scan_en, r_proc_en, r_mode, r_irq_en, r_done, r_err;

    logic          w_acc, w_wr, w_busy, w_ctrl, w_sh, w_cw, w_pe_next, w_go, w_err_set, w_unused;
    logic [4:0]    w_idx;
    logic [31:0]   w_bmask, w_sh_rd, w_ctrl_rd, w_rdata;
    logic [SB-1:0] w_wmask;

    assign w_acc     = wbs_cyc_i & wbs_stb_i & ~r_ack;
    assign w_wr      = w_acc & wbs_we_i;
    assign w_busy    = r_state != IDLE;
    assign w_idx     = wbs_adr_i[6:2];
    assign w_ctrl    = wbs_adr_i[7:0] == 8'h00;
    assign w_sh      = wbs_adr_i[7] & (wbs_adr_i[1:0] == 2'b00) & ({27'd0, w_idx} < 32'(SHADOW_W));
    assign w_cw      = w_wr & w_ctrl & wbs_sel_i[0];
    assign w_pe_next = (w_cw & ~w_busy) ? wbs_dat_i[1] : r_proc_en;
    assign w_go      = w_cw & ~w_busy & wbs_dat_i[0];
    // Attempts to change proc_en/mode or the shadow while the chain is moving are dropped and flagged
    assign w_err_set = (w_go & w_pe_next) | (w_busy & w_wr & w_sh) |
                       (w_busy & w_cw & (wbs_dat_i[2:1] != {r_mode, r_proc_en}));
    assign w_bmask   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign w_wmask   = (SB'(w_bmask) << (32 * w_idx)) & MASK;
    assign w_sh_rd   = 32'(r_shadow >> (32 * w_idx));
    assign w_ctrl_rd = {16'(CHAIN_LEN), 9'd0, r_err, r_done, halt_in, r_irq_en, r_mode, r_proc_en, w_busy};
    assign w_rdata   = w_ctrl ? w_ctrl_rd : w_sh ? w_sh_rd : 32'd0;
    assign w_unused  = ^wbs_adr_i[31:8];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= IDLE;
            r_shadow  <= '0;
            r_sr      <= '0;
            r_cnt     <= '0;
            r_dat     <= '0;
            r_ack     <= 1'b0;
            r_scan_en <= 1'b0;
            r_proc_en <= 1'b0;
            r_mode    <= 1'b0;
            r_irq_en  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_ack <= w_acc;
            r_dat <= (w_acc & ~wbs_we_i) ? w_rdata : 32'd0;
            if (w_cw & ~w_busy) begin
                r_proc_en <= wbs_dat_i[1];
                r_mode    <= wbs_dat_i[2];
            end
            if (w_cw)
                r_irq_en <= wbs_dat_i[3];
            r_err  <= w_err_set | (r_err & ~(w_cw & wbs_dat_i[6]));
            r_done <= (r_state == DONE) | (r_done & ~(w_cw & wbs_dat_i[5]));
            if (w_wr & w_sh & ~w_busy)
                r_shadow <= (r_shadow & ~w_wmask) | ({SHADOW_W{wbs_dat_i}} & w_wmask);
            case (r_state)
                IDLE: if (w_go & ~w_pe_next) r_state <= LOAD;
                LOAD: begin
                    r_sr      <= r_shadow[CHAIN_LEN-1:0];
                    r_cnt     <= CW'(CHAIN_LEN - 1);
                    r_scan_en <= 1'b1;
                    r_state   <= SHIFT;
                end
                SHIFT: begin
                    r_sr  <= (r_sr << 1) | CHAIN_LEN'(scan_out);
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_scan_en <= 1'b0;
                        r_state   <= DONE;
                    end
                end
                default: begin
                    r_shadow <= SB'(r_sr);
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign wbs_ack_o   = r_ack;
    assign wbs_dat_o   = r_dat;
    assign scan_enable = r_scan_en;
    // Readback recirculates the chain so it ends unchanged
    assign scan_in     = r_scan_en & (r_mode ? scan_out : r_sr[CHAIN_LEN-1]);
    assign proc_en     = r_proc_en;
    assign irq_o       = r_done & r_irq_en;
endmodule

// File: tb/tb_wb_scan_chain_ctrl.sv
// tb_wb_scan_chain_ctrl: scoreboard bench for the scan chain controller at 64 and 40 bit chain lengths
module tb_wb_scan_chain_ctrl;
    typedef struct {string nm; logic [31:0] exp;} rd_t;
    typedef struct {string nm; logic [63:0] act; logic [63:0] exp;} chk_t;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic        stb = 1'b0, we = 1'b0, cyc_a = 1'b0, cyc_b = 1'b0, halt = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] adr = '0, dat = '0;
    logic        ack_a, ack_b, se_a, se_b, si_a, si_b, pe_a, pe_b, irq_a, irq_b;
    logic [31:0] dat_a, dat_b;

    logic [63:0] chain_a = '0, ld_val = '0;
    logic [39:0] chain_b = '0;
    logic        ld_a = 1'b0;

    wb_scan_chain_ctrl #(.CHAIN_LEN(64)) u_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc_a), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack_a), .wbs_dat_o(dat_a),
        .scan_enable(se_a), .scan_in(si_a), .scan_out(chain_a[63]), .proc_en(pe_a),
        .halt_in(halt), .irq_o(irq_a));

    wb_scan_chain_ctrl #(.CHAIN_LEN(40)) u_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc_b), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack_b), .wbs_dat_o(dat_b),
        .scan_enable(se_b), .scan_in(si_b), .scan_out(chain_b[39]), .proc_en(pe_b),
        .halt_in(halt), .irq_o(irq_b));

    // Chain models: scan_in enters bit 0, scan_out is the top bit
    always @(posedge clk) if (ld_a) chain_a <= ld_val; else if (se_a) chain_a <= {chain_a[62:0], si_a};
    always @(posedge clk) if (se_b) chain_b <= {chain_b[38:0], si_b};

    int   se_cnt_a = 0, se_cnt_b = 0;
    logic se_prev_a = 1'b0, se_prev_b = 1'b0, first_a = 1'b0, first_b = 1'b0;
    always @(posedge clk) begin
        if (se_a) se_cnt_a <= se_cnt_a + 1;
        if (se_b) se_cnt_b <= se_cnt_b + 1;
        if (se_a & ~se_prev_a) first_a <= si_a;
        if (se_b & ~se_prev_b) first_b <= si_b;
        se_prev_a <= se_a;
        se_prev_b <= se_b;
    end

    rd_t  rq[$];
    chk_t dq[$];
    int   n_cmp = 0, n_bad = 0;
    rd_t  r_pop;
    chk_t c_pop;
    logic cur_rd = 1'b0;
    always @(posedge clk) cur_rd <= (cyc_a | cyc_b) & stb & ~we;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if ((ack_a | ack_b) && cur_rd) begin
            if (rq.size() == 0) cmp("unexpected_read", 64'(ack_a ? dat_a : dat_b), 64'hDEAD);
            else begin
                r_pop = rq.pop_front();
                cmp(r_pop.nm, 64'(ack_a ? dat_a : dat_b), 64'(r_pop.exp));
            end
        end
        while (dq.size() > 0) begin
            c_pop = dq.pop_front();
            cmp(c_pop.nm, c_pop.act, c_pop.exp);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_t c;
        c.nm = nm; c.act = act; c.exp = exp;
        dq.push_back(c);
    endtask

    task automatic bus(input bit b, input bit w, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] e, input string nm);
        int  k;
        rd_t r;
        @(negedge clk);
        adr = {24'd0, a}; dat = d; we = w; stb = 1'b1; cyc_a = ~b; cyc_b = b;
        if (!w) begin
            r.nm = nm; r.exp = e;
            rq.push_back(r);
        end
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!(b ? ack_b : ack_a) && k < 8);
        if (!(b ? ack_b : ack_a)) chk({nm, "_ack_timeout"}, 64'(k), 64'd1);
        stb = 1'b0; cyc_a = 1'b0; cyc_b = 1'b0;
    endtask

    task automatic wr(input bit b, input logic [7:0] a, input logic [31:0] d);
        bus(b, 1'b1, a, d, 32'd0, "wr");
    endtask

    task automatic rd(input bit b, input logic [7:0] a, input logic [31:0] e, input string nm);
        bus(b, 1'b0, a, 32'd0, e, nm);
    endtask

    task automatic wait_irq(input bit b, output int k);
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!(b ? irq_b : irq_a) && k < 300);
    endtask

    task automatic load_chain(input logic [63:0] v);
        @(negedge clk); ld_val = v; ld_a = 1'b1;
        @(negedge clk); ld_a = 1'b0;
    endtask

    initial begin
        int k, c0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_outputs", 64'({ack_a, dat_a, se_a, si_a, pe_a, irq_a}), 64'd0);
        rd(0, 8'h00, 32'h0040_0000, "ctrl_rst");
        rd(0, 8'h80, 32'h0, "sh0_rst");
        wr(0, 8'h80, 32'h1234_5678);
        wr(0, 8'h84, 32'hCAFE_F00D);
        rd(0, 8'h80, 32'h1234_5678, "sh0_wr");
        rd(0, 8'h84, 32'hCAFE_F00D, "sh1_wr");
        // exchange 1: chain starts at zero
        c0 = se_cnt_a;
        wr(0, 8'h00, 32'h9);
        wait_irq(0, k);
        chk("lat64_x1", 64'(k), 64'd66);
        @(negedge clk);
        chk("se_cnt64", 64'(se_cnt_a - c0), 64'd64);
        chk("first_bit64", 64'(first_a), 64'd1);
        chk("chain_x1", chain_a, 64'hCAFE_F00D_1234_5678);
        rd(0, 8'h80, 32'h0, "sh0_x1");
        rd(0, 8'h84, 32'h0, "sh1_x1");
        rd(0, 8'h00, 32'h0040_0028, "ctrl_done");
        // exchange 2 returns the original image
        wr(0, 8'h00, 32'h29);
        wait_irq(0, k);
        chk("lat64_x2", 64'(k), 64'd66);
        rd(0, 8'h80, 32'h1234_5678, "sh0_x2");
        rd(0, 8'h84, 32'hCAFE_F00D, "sh1_x2");
        chk("chain_x2", chain_a, 64'h0);
        // readback
        load_chain({8{8'hA5}});
        wr(0, 8'h00, 32'h2D);
        wait_irq(0, k);
        rd(0, 8'h80, 32'hA5A5_A5A5, "sh0_rb");
        rd(0, 8'h84, 32'hA5A5_A5A5, "sh1_rb");
        chk("chain_rb", chain_a, {8{8'hA5}});
        rd(0, 8'h00, 32'h0040_002C, "ctrl_rb");
        // GO together with proc_en is rejected
        halt = 1'b1;
        c0 = se_cnt_a;
        wr(0, 8'h00, 32'h23);
        repeat (6) @(negedge clk);
        chk("go_rej_se", 64'(se_cnt_a - c0), 64'd0);
        chk("go_rej_pe", 64'(pe_a), 64'd1);
        rd(0, 8'h00, 32'h0040_0052, "ctrl_err");
        wr(0, 8'h00, 32'h40);
        rd(0, 8'h00, 32'h0040_0010, "ctrl_err_clr");
        halt = 1'b0;
        // shadow write during shift is dropped
        load_chain(64'h0123_4567_89AB_CDEF);
        wr(0, 8'h00, 32'h9);
        repeat (3) @(negedge clk);
        wr(0, 8'h80, 32'hDEAD_BEEF);
        wait_irq(0, k);
        rd(0, 8'h80, 32'h89AB_CDEF, "sh0_busywr");
        rd(0, 8'h84, 32'h0123_4567, "sh1_busywr");
        rd(0, 8'h00, 32'h0040_0068, "ctrl_busywr");
        chk("chain_busywr", chain_a, {8{8'hA5}});
        wr(0, 8'h00, 32'h60);
        // reset in the middle of a shift
        wr(0, 8'h00, 32'h1);
        c0 = se_cnt_a;
        k = 0;
        while (se_cnt_a - c0 < 10 && k < 100) begin @(negedge clk); k++; end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid", 64'({ack_a, dat_a, se_a, si_a, pe_a, irq_a}), 64'd0);
        @(negedge clk); rst = 1'b0;
        rd(0, 8'h00, 32'h0040_0000, "ctrl_after_rst");
        load_chain(64'hFEDC_BA98_7654_3210);
        wr(0, 8'h80, 32'h0BAD_F00D);
        wr(0, 8'h84, 32'h600D_CAFE);
        wr(0, 8'h00, 32'h9);
        wait_irq(0, k);
        chk("lat64_fresh", 64'(k), 64'd66);
        rd(0, 8'h80, 32'h7654_3210, "sh0_fresh");
        rd(0, 8'h84, 32'hFEDC_BA98, "sh1_fresh");
        chk("chain_fresh", chain_a, 64'h600D_CAFE_0BAD_F00D);
        sel = 4'b0010;
        wr(0, 8'h80, 32'hFFFF_FFFF);
        sel = 4'hF;
        rd(0, 8'h80, 32'h7654_FF10, "sh0_bytelane");
        // 40-bit chain
        rd(1, 8'h00, 32'h0028_0000, "ctrl40_rst");
        wr(1, 8'h84, 32'hFFFF_FFFF);
        rd(1, 8'h84, 32'h0000_00FF, "sh1_40_mask");
        rd(1, 8'h88, 32'h0, "unmapped40");
        c0 = se_cnt_b;
        wr(1, 8'h00, 32'h9);
        wait_irq(1, k);
        chk("lat40", 64'(k), 64'd42);
        chk("irq40_high", 64'(irq_b), 64'd1);
        @(negedge clk);
        chk("se_cnt40", 64'(se_cnt_b - c0), 64'd40);
        chk("first_bit40", 64'(first_b), 64'd1);
        chk("chain40", 64'(chain_b), 64'h00FF_0000_0000);
        wr(1, 8'h00, 32'h28);
        @(negedge clk);
        chk("irq40_low", 64'(irq_b), 64'd0);
        rd(1, 8'h80, 32'h0, "sh0_40");
        rd(1, 8'h84, 32'h0, "sh1_40");
        repeat (3) @(negedge clk);
        chk("rd_queue_drained", 64'(rq.size()), 64'd0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
